// File: rtl/nand_flash_responder.sv
// NAND flash target model: decodes host command/address/data latch cycles,
// drives Readybusy and RE_N read data, backed by a small register page array.
module nand_flash_responder #(
  parameter int PAGE_BYTES = 128,
  parameter int PAGE_AW    = 3,
  parameter int ERASE_BUSY = 40,
  parameter int PROG_BUSY  = 30,
  parameter int READ_BUSY  = 12,
  parameter int RST_BUSY   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       CLEi,
  input  logic       ALEi,
  input  logic       CE_N,
  input  logic       RE_N,
  input  logic       WE_N,
  input  logic [7:0] DIO_IN,
  output logic [7:0] DIO_OUT,
  output logic       DIO_OE,
  output logic       Readybusy,
  output logic       cmd_err
);

  localparam int NUM_PAGES = 2 ** PAGE_AW;
  localparam int CW        = $clog2(PAGE_BYTES);
  localparam int CNT_W     = 16;

  localparam logic [7:0] CMD_READ     = 8'h00;
  localparam logic [7:0] CMD_READ_GO  = 8'h30;
  localparam logic [7:0] CMD_PROG     = 8'h80;
  localparam logic [7:0] CMD_PROG_GO  = 8'h10;
  localparam logic [7:0] CMD_ERASE    = 8'h60;
  localparam logic [7:0] CMD_ERASE_GO = 8'hD0;
  localparam logic [7:0] CMD_STATUS   = 8'h70;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  // state   | meaning
  // IDLE    | waiting for an opcode
  // ER_*    | erase: 2 row bytes, then D0h confirm
  // PG_*    | program: 4 address bytes, then data bytes until 10h
  // RD_*    | read: 4 address bytes, then 30h confirm
  // BUSY    | Readybusy low, countdown running
  // RD_OUT  | read strobes stream page bytes
  // STATUS  | read strobes return status; saved holds the state to resume
  typedef enum logic [3:0] {
    IDLE, ER_ADDR, ER_CONF, PG_ADDR, PG_DATA, RD_ADDR, RD_CONF, BUSY, RD_OUT, STATUS
  } state_t;

  typedef enum logic [1:0] {OP_ERASE, OP_PROG, OP_READ, OP_RST} op_t;

  state_t             state, state_nxt, saved, saved_nxt, target;
  op_t                op, op_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               rdy, rdy_nxt, fail, fail_nxt, err, err_nxt, oe, oe_nxt;
  logic [CW-1:0]      col, col_nxt, col_inc;
  logic [7:0]         col_lo, col_lo_nxt, dout, dout_nxt, mem_rd;
  logic [PAGE_AW-1:0] page, page_nxt;
  logic [1:0]         acnt, acnt_nxt;
  logic               we_r, re_r, we_rise, re_fall;
  logic               er_wr, pg_wr, go, bad;
  logic [7:0]         mem [NUM_PAGES][PAGE_BYTES];

  assign we_rise = !CE_N && !we_r && WE_N;
  assign re_fall = !CE_N && re_r && !RE_N;
  assign mem_rd  = mem[page][col];
  assign col_inc = (col == CW'(PAGE_BYTES - 1)) ? '0 : col + CW'(1);

  assign DIO_OUT   = dout;
  assign DIO_OE    = oe;
  assign Readybusy = rdy;
  assign cmd_err   = err;

  always_comb begin
    state_nxt  = state;
    saved_nxt  = saved;
    op_nxt     = op;
    cnt_nxt    = cnt;
    rdy_nxt    = rdy;
    fail_nxt   = fail;
    err_nxt    = 1'b0;
    oe_nxt     = oe;
    col_nxt    = col;
    col_lo_nxt = col_lo;
    dout_nxt   = dout;
    page_nxt   = page;
    acnt_nxt   = acnt;
    er_wr      = 1'b0;
    pg_wr      = 1'b0;
    go         = 1'b0;
    bad        = 1'b0;
    target     = IDLE;

    // Countdown keeps running while STATUS is shown; completion then retargets saved.
    if (!rdy && !CE_N) begin
      if (cnt == '0) begin
        rdy_nxt = 1'b1;
        er_wr   = (op == OP_ERASE);
        target  = (op == OP_READ) ? RD_OUT : IDLE;
        if (state == BUSY) state_nxt = target;
        else if (state == STATUS) saved_nxt = target;
      end else begin
        cnt_nxt = cnt - CNT_W'(1);
      end
    end

    if (RE_N || CE_N) oe_nxt = 1'b0;

    if (we_rise) begin
      if (CLEi && ALEi) begin
        err_nxt = 1'b1;
      end else if (CLEi) begin
        if (DIO_IN == CMD_RESET) begin
          fail_nxt = 1'b0;
          op_nxt   = OP_RST;
          cnt_nxt  = CNT_W'(RST_BUSY - 1);
          go       = 1'b1;
        end else if (DIO_IN == CMD_STATUS) begin
          if (state != STATUS) saved_nxt = state;
          state_nxt = STATUS;
        end else if (!rdy) begin
          err_nxt = 1'b1;
        end else begin
          case (state)
            ER_CONF: begin
              if (DIO_IN == CMD_ERASE_GO) begin
                op_nxt  = OP_ERASE;
                cnt_nxt = CNT_W'(ERASE_BUSY - 1);
                go      = 1'b1;
              end else bad = 1'b1;
            end
            PG_DATA: begin
              if (DIO_IN == CMD_PROG_GO) begin
                op_nxt  = OP_PROG;
                cnt_nxt = CNT_W'(PROG_BUSY - 1);
                go      = 1'b1;
              end else bad = 1'b1;
            end
            RD_CONF: begin
              if (DIO_IN == CMD_READ_GO) begin
                op_nxt  = OP_READ;
                cnt_nxt = CNT_W'(READ_BUSY - 1);
                go      = 1'b1;
              end else bad = 1'b1;
            end
            IDLE, RD_OUT, STATUS: begin
              acnt_nxt = '0;
              if (state == STATUS && saved == RD_OUT && DIO_IN == CMD_READ) begin
                state_nxt = RD_OUT;
              end else begin
                case (DIO_IN)
                  CMD_ERASE: begin state_nxt = ER_ADDR; fail_nxt = 1'b0; end
                  CMD_PROG:  begin state_nxt = PG_ADDR; fail_nxt = 1'b0; end
                  CMD_READ:  state_nxt = RD_ADDR;
                  default:   bad = 1'b1;
                endcase
              end
            end
            default: bad = 1'b1;
          endcase
        end
      end else if (ALEi) begin
        if (!rdy) begin
          err_nxt = 1'b1;
        end else begin
          case (state)
            ER_ADDR: begin
              if (acnt == 2'd0) page_nxt = DIO_IN[PAGE_AW-1:0];
              else state_nxt = ER_CONF;
              acnt_nxt = acnt + 2'd1;
            end
            PG_ADDR, RD_ADDR: begin
              case (acnt)
                2'd0:    col_lo_nxt = DIO_IN;
                2'd1:    col_nxt = CW'(32'({DIO_IN, col_lo}) % PAGE_BYTES);
                2'd2:    page_nxt = DIO_IN[PAGE_AW-1:0];
                default: state_nxt = (state == PG_ADDR) ? PG_DATA : RD_CONF;
              endcase
              acnt_nxt = acnt + 2'd1;
            end
            default: bad = 1'b1;
          endcase
        end
      end else begin
        if (!rdy) begin
          err_nxt = 1'b1;
        end else if (state == PG_DATA) begin
          pg_wr   = 1'b1;
          col_nxt = col_inc;
          if ((DIO_IN & ~mem_rd) != 8'h00) fail_nxt = 1'b1;
        end else begin
          bad = 1'b1;
        end
      end
      // A read strobe landing on the same edge as a latch is dropped and flagged.
      if (re_fall) err_nxt = 1'b1;
    end else if (re_fall) begin
      oe_nxt = 1'b1;
      case (state)
        RD_OUT: begin
          dout_nxt = mem_rd;
          col_nxt  = col_inc;
        end
        STATUS:  dout_nxt = {1'b1, rdy, 5'b0, fail};
        default: dout_nxt = 8'hFF;
      endcase
    end

    if (bad) begin
      err_nxt   = 1'b1;
      state_nxt = IDLE;
    end
    if (go) begin
      state_nxt = BUSY;
      rdy_nxt   = 1'b0;
      er_wr     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      saved  <= IDLE;
      op     <= OP_RST;
      cnt    <= '0;
      rdy    <= 1'b1;
      fail   <= 1'b0;
      err    <= 1'b0;
      oe     <= 1'b0;
      col    <= '0;
      col_lo <= 8'h00;
      dout   <= 8'h00;
      page   <= '0;
      acnt   <= '0;
      we_r   <= 1'b1;
      re_r   <= 1'b1;
    end else begin
      state  <= state_nxt;
      saved  <= saved_nxt;
      op     <= op_nxt;
      cnt    <= cnt_nxt;
      rdy    <= rdy_nxt;
      fail   <= fail_nxt;
      err    <= err_nxt;
      oe     <= oe_nxt;
      col    <= col_nxt;
      col_lo <= col_lo_nxt;
      dout   <= dout_nxt;
      page   <= page_nxt;
      acnt   <= acnt_nxt;
      we_r   <= WE_N;
      re_r   <= RE_N;
    end
  end

  // Array contents survive reset; only erase defines them.
  always_ff @(posedge clk) begin
    if (er_wr) begin
      for (int i = 0; i < PAGE_BYTES; i++) mem[page][i] <= 8'hFF;
    end else if (pg_wr) begin
      mem[page][col] <= mem_rd & DIO_IN;
    end
  end

endmodule

// File: tb/tb_nand_flash_responder.sv
// Closed-loop bench for nand_flash_responder: host-side latch/strobe tasks,
// expected read bytes queued at stimulus time and popped on each strobe.
module tb_nand_flash_responder;

  localparam int PAGE_BYTES = 128;
  localparam int ERASE_BUSY = 40;
  localparam int PROG_BUSY  = 30;
  localparam int READ_BUSY  = 12;
  localparam int RST_BUSY   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       CLEi = 1'b0;
  logic       ALEi = 1'b0;
  logic       CE_N = 1'b1;
  logic       RE_N = 1'b1;
  logic       WE_N = 1'b1;
  logic [7:0] DIO_IN = 8'h00;
  logic [7:0] DIO_OUT;
  logic       DIO_OE;
  logic       Readybusy;
  logic       cmd_err;

  int tests_run = 0;
  int fails = 0;
  int err_cnt = 0;
  logic [7:0] exp_q [$];

  nand_flash_responder #(
    .PAGE_BYTES(PAGE_BYTES), .PAGE_AW(3), .ERASE_BUSY(ERASE_BUSY),
    .PROG_BUSY(PROG_BUSY), .READ_BUSY(READ_BUSY), .RST_BUSY(RST_BUSY)
  ) dut (
    .clk(clk), .rst(rst), .CLEi(CLEi), .ALEi(ALEi), .CE_N(CE_N), .RE_N(RE_N),
    .WE_N(WE_N), .DIO_IN(DIO_IN), .DIO_OUT(DIO_OUT), .DIO_OE(DIO_OE),
    .Readybusy(Readybusy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cmd_err === 1'b1) err_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic latch(input logic cle, input logic ale, input logic [7:0] b);
    @(negedge clk); CLEi = cle; ALEi = ale; DIO_IN = b; WE_N = 1'b0;
    @(negedge clk); WE_N = 1'b1;
    @(negedge clk); CLEi = 1'b0; ALEi = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] b);  latch(1'b1, 1'b0, b); endtask
  task automatic addr(input logic [7:0] b); latch(1'b0, 1'b1, b); endtask
  task automatic data(input logic [7:0] b); latch(1'b0, 1'b0, b); endtask

  task automatic strobe(output logic [7:0] d, output logic o);
    @(negedge clk); RE_N = 1'b0;
    @(negedge clk); d = DIO_OUT; o = DIO_OE; RE_N = 1'b1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (Readybusy !== 1'b1 && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (n >= 500) begin
      tests_run++; fails++;
      $display("FAIL ready_timeout: Readybusy still %b after %0d cycles", Readybusy, n);
    end
  endtask

  task automatic erase_page(input logic [7:0] p);
    int n;
    cmd(8'h60); addr(p); addr(8'h00); cmd(8'hD0);
    wait_ready(n);
  endtask

  task automatic open_read(input logic [7:0] c, input logic [7:0] p, output int n);
    cmd(8'h00); addr(c); addr(8'h00); addr(p); addr(8'h00); cmd(8'h30);
    wait_ready(n);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    CE_N = 1'b0;
    tests_run++; if (DIO_OUT !== 8'h00) begin fails++; $display("FAIL rst_dout: got %02h expected 00", DIO_OUT); end
    tests_run++; if (DIO_OE !== 1'b0) begin fails++; $display("FAIL rst_oe: got %b expected 0", DIO_OE); end
    tests_run++; if (Readybusy !== 1'b1) begin fails++; $display("FAIL rst_rb: got %b expected 1", Readybusy); end
    tests_run++; if (cmd_err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b expected 0", cmd_err); end
  endtask

  task automatic test_erase;
    int n;
    logic [7:0] d, e;
    logic o, first;
    cmd(8'h60); addr(8'h00); addr(8'h00); cmd(8'hD0);
    wait_ready(n);
    tests_run++; if (n != ERASE_BUSY) begin fails++; $display("FAIL erase_busy: got %0d cycles expected %0d", n, ERASE_BUSY); end
    cmd(8'h70); strobe(d, o);
    tests_run++; if (d !== 8'hC0) begin fails++; $display("FAIL erase_status: got %02h expected C0", d); end
    open_read(8'h00, 8'h00, n);
    tests_run++; if (n != READ_BUSY) begin fails++; $display("FAIL read_busy: got %0d cycles expected %0d", n, READ_BUSY); end
    for (int i = 0; i < PAGE_BYTES; i++) exp_q.push_back(8'hFF);
    first = 1'b1;
    while (exp_q.size() > 0) begin
      strobe(d, o);
      e = exp_q.pop_front();
      tests_run++; if (d !== e) begin fails++; $display("FAIL erase_read: got %02h expected %02h", d, e); end
      if (first) begin
        tests_run++; if (o !== 1'b1) begin fails++; $display("FAIL read_oe: got %b expected 1", o); end
      end
      first = 1'b0;
    end
  endtask

  task automatic test_program;
    int n;
    logic [7:0] d, e;
    logic o;
    erase_page(8'h04);
    cmd(8'h80); addr(8'h00); addr(8'h00); addr(8'h04); addr(8'h00);
    for (int i = 0; i < PAGE_BYTES; i++) data(8'h55);
    cmd(8'h10);
    wait_ready(n);
    tests_run++; if (n != PROG_BUSY) begin fails++; $display("FAIL prog_busy: got %0d cycles expected %0d", n, PROG_BUSY); end
    open_read(8'h00, 8'h04, n);
    for (int i = 0; i <= PAGE_BYTES; i++) exp_q.push_back(8'h55);
    while (exp_q.size() > 0) begin
      strobe(d, o);
      e = exp_q.pop_front();
      tests_run++; if (d !== e) begin fails++; $display("FAIL prog_read: got %02h expected %02h", d, e); end
    end
  endtask

  task automatic test_fail_flag;
    int n;
    logic [7:0] d, e;
    logic o;
    cmd(8'h80); addr(8'h00); addr(8'h00); addr(8'h04); addr(8'h00);
    data(8'hAA); cmd(8'h10);
    wait_ready(n);
    cmd(8'h70); strobe(d, o);
    tests_run++; if (d !== 8'hC1) begin fails++; $display("FAIL fail_status: got %02h expected C1", d); end
    open_read(8'h00, 8'h04, n);
    exp_q.push_back(8'h00); exp_q.push_back(8'h55);
    while (exp_q.size() > 0) begin
      strobe(d, o);
      e = exp_q.pop_front();
      tests_run++; if (d !== e) begin fails++; $display("FAIL fail_read: got %02h expected %02h", d, e); end
    end
  endtask

  task automatic test_status_busy;
    int n;
    logic [7:0] d, e;
    logic o;
    erase_page(8'h05);
    cmd(8'h80); addr(8'h02); addr(8'h00); addr(8'h05); addr(8'h00);
    data(8'h3C); cmd(8'h10);
    cmd(8'h70); strobe(d, o);
    tests_run++; if (d !== 8'h80) begin fails++; $display("FAIL busy_status: got %02h expected 80", d); end
    tests_run++; if (Readybusy !== 1'b0) begin fails++; $display("FAIL busy_rb: got %b expected 0", Readybusy); end
    wait_ready(n);
    tests_run++; if (n != PROG_BUSY - 5) begin fails++; $display("FAIL busy_remaining: got %0d cycles expected %0d", n, PROG_BUSY - 5); end
    strobe(d, o);
    tests_run++; if (d !== 8'hC0) begin fails++; $display("FAIL ready_status: got %02h expected C0", d); end
    open_read(8'h02, 8'h05, n);
    exp_q.push_back(8'h3C); exp_q.push_back(8'hC0); exp_q.push_back(8'hFF);
    strobe(d, o);
    e = exp_q.pop_front();
    tests_run++; if (d !== e) begin fails++; $display("FAIL status_rd0: got %02h expected %02h", d, e); end
    cmd(8'h70); strobe(d, o);
    e = exp_q.pop_front();
    tests_run++; if (d !== e) begin fails++; $display("FAIL status_mid: got %02h expected %02h", d, e); end
    cmd(8'h00); strobe(d, o);
    e = exp_q.pop_front();
    tests_run++; if (d !== e) begin fails++; $display("FAIL status_resume: got %02h expected %02h", d, e); end
  endtask

  task automatic test_seq_err;
    int e0;
    logic [7:0] d;
    logic o;
    e0 = err_cnt;
    cmd(8'h80); addr(8'h00); addr(8'h00); addr(8'h01); addr(8'h00);
    cmd(8'hD0); @(negedge clk);
    tests_run++; if (err_cnt != e0 + 1) begin fails++; $display("FAIL wrong_confirm_err: got %0d pulses expected 1", err_cnt - e0); end
    tests_run++; if (Readybusy !== 1'b1) begin fails++; $display("FAIL wrong_confirm_rb: got %b expected 1", Readybusy); end
    strobe(d, o);
    tests_run++; if (d !== 8'hFF) begin fails++; $display("FAIL idle_read: got %02h expected FF", d); end
    latch(1'b1, 1'b1, 8'h70); @(negedge clk);
    tests_run++; if (err_cnt != e0 + 2) begin fails++; $display("FAIL cle_ale_err: got %0d pulses expected 2", err_cnt - e0); end
    strobe(d, o);
    tests_run++; if (d !== 8'hFF) begin fails++; $display("FAIL cle_ale_ignored: got %02h expected FF", d); end
    cmd(8'h5A); @(negedge clk);
    tests_run++; if (err_cnt != e0 + 3) begin fails++; $display("FAIL bad_opcode_err: got %0d pulses expected 3", err_cnt - e0); end
    data(8'h12); @(negedge clk);
    tests_run++; if (err_cnt != e0 + 4) begin fails++; $display("FAIL stray_data_err: got %0d pulses expected 4", err_cnt - e0); end
    CE_N = 1'b1;
    cmd(8'hFF); @(negedge clk);
    tests_run++; if (Readybusy !== 1'b1) begin fails++; $display("FAIL ce_high_rb: got %b expected 1", Readybusy); end
    CE_N = 1'b0;
    @(negedge clk);
    tests_run++; if (err_cnt != e0 + 4) begin fails++; $display("FAIL ce_high_err: got %0d pulses expected 4", err_cnt - e0); end
  endtask

  task automatic test_abort;
    int n;
    logic [7:0] d, e;
    logic o;
    cmd(8'h60); addr(8'h04); addr(8'h00); cmd(8'hD0);
    repeat (5) @(negedge clk);
    cmd(8'hFF);
    wait_ready(n);
    tests_run++; if (n != RST_BUSY) begin fails++; $display("FAIL abort_busy: got %0d cycles expected %0d", n, RST_BUSY); end
    open_read(8'h00, 8'h04, n);
    exp_q.push_back(8'h00); exp_q.push_back(8'h55);
    while (exp_q.size() > 0) begin
      strobe(d, o);
      e = exp_q.pop_front();
      tests_run++; if (d !== e) begin fails++; $display("FAIL abort_read: got %02h expected %02h", d, e); end
    end
  endtask

  task automatic test_back_to_back;
    int e0;
    logic [7:0] d;
    logic o;
    e0 = err_cnt;
    @(negedge clk); CLEi = 1'b1; DIO_IN = 8'h70; WE_N = 1'b0;
    @(negedge clk); WE_N = 1'b1; RE_N = 1'b0;
    @(negedge clk); CLEi = 1'b0; RE_N = 1'b1;
    @(negedge clk);
    tests_run++; if (err_cnt != e0 + 1) begin fails++; $display("FAIL collide_err: got %0d pulses expected 1", err_cnt - e0); end
    strobe(d, o);
    tests_run++; if (d !== 8'hC0) begin fails++; $display("FAIL collide_status: got %02h expected C0", d); end
  endtask

  task automatic test_reset_midbusy;
    int n, e0;
    logic [7:0] d, e;
    logic o;
    cmd(8'h00); addr(8'h01); addr(8'h00); addr(8'h04); addr(8'h00); cmd(8'h30);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++; if (Readybusy !== 1'b1) begin fails++; $display("FAIL midrst_rb: got %b expected 1", Readybusy); end
    tests_run++; if (DIO_OE !== 1'b0) begin fails++; $display("FAIL midrst_oe: got %b expected 0", DIO_OE); end
    @(negedge clk);
    rst = 1'b1;
    e0 = err_cnt;
    open_read(8'h01, 8'h04, n);
    tests_run++; if (n != READ_BUSY) begin fails++; $display("FAIL midrst_busy: got %0d cycles expected %0d", n, READ_BUSY); end
    exp_q.push_back(8'h55);
    strobe(d, o);
    e = exp_q.pop_front();
    tests_run++; if (d !== e) begin fails++; $display("FAIL midrst_read: got %02h expected %02h", d, e); end
    tests_run++; if (err_cnt != e0) begin fails++; $display("FAIL midrst_err: got %0d pulses expected 0", err_cnt - e0); end
  endtask

  initial begin
    test_reset;
    test_erase;
    test_program;
    test_fail_flag;
    test_status_busy;
    test_seq_err;
    test_abort;
    test_back_to_back;
    test_reset_midbusy;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/nand_flash_responder.md
Name: nand_flash_responder

Overview:
- Synthesizable NAND flash target model; the device end of the host-side NAND flash interface, sharing its clock domain.
- Decodes CLE/ALE/WE_N-latched command, address and data cycles, and drives Readybusy and read data on RE_N.
- Supports erase (60h/D0h), program (80h/10h), read (00h/30h), status (70h) and reset (FFh) over a small page array.
- Used as the bench/FPGA stand-in for the flash part, so the interface controller can be exercised closed-loop.

Parameters:
- PAGE_BYTES, 128, bytes per page; column index wraps modulo PAGE_BYTES.
- PAGE_AW, 3, page-select bits taken from ROW1 address byte[PAGE_AW-1:0]; NUM_PAGES = 2**PAGE_AW.
- ERASE_BUSY, 40, Readybusy-low cycles after D0h.
- PROG_BUSY, 30, Readybusy-low cycles after 10h.
- READ_BUSY, 12, Readybusy-low cycles after 30h.
- RST_BUSY, 4, Readybusy-low cycles after FFh.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- CLEi  in  1  command latch enable from host
- ALEi  in  1  address latch enable from host
- CE_N  in  1  chip enable, active low
- RE_N  in  1  read enable, active low
- WE_N  in  1  write enable, active low; latch on rising edge
- DIO_IN  in  8  host-driven bus
- DIO_OUT  out  8  device-driven read data
- DIO_OE  out  1  high while DIO_OUT is valid
- Readybusy  out  1  1 = ready, 0 = busy
- cmd_err  out  1  one-cycle pulse on illegal or out-of-sequence cycle

Behaviour:
- Reset: DIO_OUT=00h, DIO_OE=0, Readybusy=1, cmd_err=0, state=IDLE, fail flag=0, counters=0. Page array is not reset; contents are undefined until erased. Reset mid-busy aborts the operation and leaves any partial array update as is.
- Latch event: registered WE_N goes 0 then 1 while CE_N=0. CLEi=1 means command byte, ALEi=1 means address byte, neither means data byte. CLEi and ALEi both high is an error: cmd_err pulses and the cycle is ignored.
- Read strobe: registered RE_N goes 1 then 0 while CE_N=0. DIO_OUT updates on the next clk. DIO_OE=1 from that cycle until RE_N returns high or CE_N goes high.
- States: IDLE, ER_ADDR, ER_CONF, PG_ADDR, PG_DATA, RD_ADDR, RD_CONF, BUSY, RD_OUT, STATUS.
- IDLE, command 60h: go to ER_ADDR; expect 2 row bytes, then ER_CONF.
  - ER_CONF, D0h: enter BUSY for ERASE_BUSY cycles, then fill the selected page with FFh.
- IDLE, command 80h: go to PG_ADDR; expect COL1, COL2, ROW1, ROW2, then PG_DATA.
  - Column = {COL2,COL1} mod PAGE_BYTES.
  - PG_DATA, each data byte: mem = mem & DIN. Column increments and wraps to 0 after PAGE_BYTES-1.
  - If any DIN bit is 1 where mem is 0, set fail.
  - PG_DATA, command 10h: enter BUSY for PROG_BUSY cycles.
- IDLE, command 00h: go to RD_ADDR; 4 address bytes as for program, then RD_CONF.
  - RD_CONF, 30h: enter BUSY for READ_BUSY cycles, then RD_OUT.
  - RD_OUT: each read strobe returns mem[page][col], then col++ with wrap.
- 70h in any state: enter STATUS, previous state saved. Read strobes return {1'b1, Readybusy, 5'b0, fail}, i.e. C0h when ready and pass, 80h when busy.
  - A following 00h with no address cycles returns to RD_OUT at the current column.
  - Any other command leaves STATUS as if issued from IDLE. BUSY countdown continues underneath STATUS.
- FFh in any state: abort the current operation, clear fail, enter BUSY for RST_BUSY cycles, then IDLE.
- 60h and 80h clear fail on entry. Fail otherwise stays set until one of those commands or FFh.
- Readybusy drops to 0 the cycle after the confirm latch. It rises the cycle after the counter hits 0, together with the array update and the state change.
- During BUSY: only 70h and FFh are accepted. Any other command, address or data latch gives a cmd_err pulse and is ignored.
- Out-of-sequence cycles give a cmd_err pulse and return to IDLE:
  - unexpected address count, or data in a non-data state;
  - an unknown opcode;
  - a wrong confirm opcode.
- Read strobe in IDLE/ADDR/CONF states: DIO_OUT=FFh, no error.
- Simultaneous WE_N rise and RE_N fall: WE_N latch takes priority; cmd_err pulses.
- CE_N high: latch and strobe detection is disabled; state and counters hold.

Test Plan:
- Erase page 0 (60h,00h,00h,D0h) -> Readybusy low exactly ERASE_BUSY cycles; then 70h read returns C0h; read of page 0 col 0..127 returns all FFh.
- Program page 4 at col 0 with 128 bytes of 55h, then 10h; read page 4 -> 128 bytes 55h. Byte 129 read wraps to col 0 and returns 55h.
- Reprogram page 4 col 0 with AAh -> status returns C1h (fail set); read col 0 returns 00h.
- 70h issued during program busy -> first read returns 80h. Readybusy stays 0 until PROG_BUSY expires; next read returns C0h.
- D0h directly after 80h+4 addr -> cmd_err single pulse, state IDLE, Readybusy stays 1. FFh mid-erase busy -> Readybusy low RST_BUSY cycles, page unchanged.
- Assert rst low for one cycle during READ_BUSY -> Readybusy=1, DIO_OE=0, state IDLE immediately. A subsequent full read sequence completes normally.
